// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake and optional skid entry.
// It also provides a synchronous flush, a bubble fill pattern and a saturating stall counter.
module pipe_stage_skid_reg #(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        LANES      = 6,
  parameter bit                 SKID       = 1'b1,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = 32'h0000_0000,
  parameter int unsigned        CNT_W      = 16
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     FLUSH,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DATA_W-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*DATA_W-1:0]  out_data,
  output logic [1:0]               occupancy,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int unsigned W = LANES * DATA_W;
  localparam logic [W-1:0] Bubble = {LANES{BUBBLE_VAL}};

  typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StFull = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     m_q, m_d, s_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept, fire;

  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;
  assign out_valid = (state_q != StEmpty);
  assign out_data  = m_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    if (FLUSH) begin
      state_d = StEmpty;
      m_d     = Bubble;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            m_d     = in_data;
          end
        end
        StOne: begin
          if (accept && !fire) begin
            state_d = StFull;
          end else if (accept && fire) begin
            m_d = in_data;
          end else if (fire) begin
            state_d = StEmpty;
            m_d     = Bubble;
          end
        end
        StFull: begin
          if (fire) begin
            state_d = StOne;
            m_d     = s_q;
          end
        end
        default: begin
          state_d = StEmpty;
          m_d     = Bubble;
        end
      endcase
    end
  end

  // Counter is deliberately untouched by FLUSH.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StEmpty;
      m_q     <= Bubble;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      stall_q <= stall_d;
    end
  end

  if (SKID) begin : g_skid
    logic [W-1:0] s_d;
    logic         in_ready_q, in_ready_d;

    always_comb begin
      s_d = s_q;
      if (FLUSH) begin
        s_d = Bubble;
      end else if (state_q == StOne && accept && !fire) begin
        s_d = in_data;
      end else if (state_q == StFull && fire) begin
        s_d = Bubble;
      end
    end

    // Registered ready breaks the combinational path from out_ready.
    assign in_ready_d = (state_d != StFull);

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        s_q        <= Bubble;
        in_ready_q <= 1'b1;
      end else begin
        s_q        <= s_d;
        in_ready_q <= in_ready_d;
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_noskid
    assign s_q      = Bubble;
    assign in_ready = !out_valid | out_ready;
  end

endmodule
